// File: rtl/conv3x3_mac.sv
// conv3x3_mac: three-stage 3x3 signed MAC with bias, round-half-up shift and OUT_W saturation.
// Build macro CONV3X3_MAC_RELU_EN additionally clamps negative results to zero.
module conv3x3_mac #(
  parameter int DATA_W  = 8,
  parameter int W_W     = 8,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int COORD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_load,
  output logic                 cfg_ready,
  input  logic [W_W*9-1:0]     cfg_weights,
  input  logic [ACC_W-1:0]     cfg_bias,
  input  logic [4:0]           cfg_shift,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W*9-1:0]  in_window,
  input  logic [COORD_W-1:0]   in_row,
  input  logic [COORD_W-1:0]   in_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [COORD_W-1:0]   out_row,
  output logic [COORD_W-1:0]   out_col
);

  localparam int P_W = DATA_W + W_W;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

  logic                     en;
  logic [W_W*9-1:0]         w_q;
  logic signed [ACC_W-1:0]  bias_q, bias1_q;
  logic [4:0]               shift_q, shift1_q, shift2_q;
  logic                     v1_q, v2_q, v3_q;
  logic signed [P_W-1:0]    p_d [9];
  logic signed [P_W-1:0]    p_q [9];
  logic signed [ACC_W-1:0]  sum_d, sum_q;
  logic [COORD_W-1:0]       row1_q, col1_q, row2_q, col2_q, row3_q, col3_q;
  logic signed [ACC_W:0]    ext, half, rq;
  logic [OUT_W-1:0]         data3_d, data3_q;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign cfg_ready = !(v1_q || v2_q || v3_q);

  assign out_valid = v3_q;
  assign out_data  = data3_q;
  assign out_row   = row3_q;
  assign out_col   = col3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      bias_q  <= '0;
      shift_q <= '0;
    end else if (cfg_load && cfg_ready) begin
      w_q     <= cfg_weights;
      bias_q  <= cfg_bias;
      shift_q <= cfg_shift;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 9; k++) begin
      p_d[k] = P_W'($signed(in_window[k*DATA_W +: DATA_W])) *
               P_W'($signed(w_q[k*W_W +: W_W]));
    end
  end

  always_comb begin
    sum_d = bias1_q;
    for (int unsigned k = 0; k < 9; k++) begin
      sum_d = sum_d + ACC_W'(p_q[k]);
    end
  end

  // Rounding add is done one bit wider so the +half term cannot overflow before the shift.
  always_comb begin
    ext  = {sum_q[ACC_W-1], sum_q};
    half = '0;
    if (shift2_q != 5'd0) half = (ACC_W+1)'(1) << (shift2_q - 5'd1);
    rq   = (shift2_q == 5'd0) ? ext : ((ext + half) >>> shift2_q);
    if (rq > SAT_MAX)      data3_d = OUT_W'(SAT_MAX);
    else if (rq < SAT_MIN) data3_d = OUT_W'(SAT_MIN);
    else                   data3_d = rq[OUT_W-1:0];
`ifdef CONV3X3_MAC_RELU_EN
    if (data3_d[OUT_W-1]) data3_d = '0;
`endif
  end

  // Bias and shift travel with the window so a same-edge config load never affects it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      for (int unsigned k = 0; k < 9; k++) p_q[k] <= '0;
      sum_q    <= '0;
      bias1_q  <= '0;
      shift1_q <= '0;
      shift2_q <= '0;
      row1_q   <= '0;
      col1_q   <= '0;
      row2_q   <= '0;
      col2_q   <= '0;
      row3_q   <= '0;
      col3_q   <= '0;
      data3_q  <= '0;
    end else if (en) begin
      v1_q     <= in_valid;
      for (int unsigned k = 0; k < 9; k++) p_q[k] <= p_d[k];
      bias1_q  <= bias_q;
      shift1_q <= shift_q;
      row1_q   <= in_row;
      col1_q   <= in_col;
      v2_q     <= v1_q;
      sum_q    <= sum_d;
      shift2_q <= shift1_q;
      row2_q   <= row1_q;
      col2_q   <= col1_q;
      v3_q     <= v2_q;
      data3_q  <= data3_d;
      row3_q   <= row2_q;
      col3_q   <= col2_q;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: directed steps plus randomized traffic checked against an arithmetic scoreboard.
module tb_conv3x3_mac;
  localparam int DATA_W = 8, W_W = 8, ACC_W = 32, OUT_W = 8, COORD_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_load, cfg_ready;
  logic [71:0] cfg_weights;
  logic [31:0] cfg_bias;
  logic [4:0]  cfg_shift;
  logic        in_valid, in_ready;
  logic [71:0] in_window;
  logic [3:0]  in_row, in_col;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_row, out_col;

  always #5 clk = ~clk;

  conv3x3_mac #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .COORD_W(COORD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_load(cfg_load), .cfg_ready(cfg_ready), .cfg_weights(cfg_weights),
    .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
    .in_row(in_row), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  typedef struct { logic [7:0] d; logic [3:0] r; logic [3:0] c; int cyc; } exp_t;
  exp_t       sb[$];
  logic [7:0] got[$];
  int         n_cmp = 0, n_fail = 0, cyc = 0, last_lat = 0;
  logic [7:0] last_d = '0;
  logic [71:0] m_w = '0;
  logic [31:0] m_b = '0;
  logic [4:0]  m_s = '0;
  bit          hold_p = 0;
  logic [7:0]  hold_d;
  logic [3:0]  hold_r, hold_c;
  bit          rand_ready = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_out(input logic [71:0] win, input logic [71:0] w,
                                         input logic [31:0] b, input logic [4:0] s);
    longint acc, q;
    int     wrapped;
    acc = longint'($signed(b));
    for (int k = 0; k < 9; k++) begin
      logic signed [7:0] a, c;
      a = win[k*8 +: 8];
      c = w[k*8 +: 8];
      acc += longint'(a) * longint'(c);
    end
    wrapped = int'(acc);
    q = longint'(wrapped);
    if (s != 0) q = (q + (longint'(1) << (s - 1))) >>> s;
    if (q > 127) q = 127;
    else if (q < -128) q = -128;
`ifdef CONV3X3_MAC_RELU_EN
    if (q < 0) q = 0;
`endif
    return 8'(q);
  endfunction

  function automatic logic [71:0] rep(input logic [7:0] v);
    return {9{v}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    bit   mready;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m_w = '0; m_b = '0; m_s = '0;
      hold_p = 0;
    end else begin
      mready = (sb.size() == 0);
      check("cfg_ready", cfg_ready, mready);
      if (hold_p) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_d);
        check("hold_row", out_row, hold_r);
        check("hold_col", out_col, hold_c);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", out_valid, 1'b0);
        else begin
          e = sb.pop_front();
          check("out_data", $signed(out_data), $signed(e.d));
          check("out_row", out_row, e.r);
          check("out_col", out_col, e.c);
          last_lat = cyc + 1 - e.cyc;
          last_d   = out_data;
          got.push_back(out_data);
        end
      end
      hold_p = out_valid && !out_ready;
      hold_d = out_data; hold_r = out_row; hold_c = out_col;
      if (in_valid && in_ready) begin
        e.d = ref_out(in_window, m_w, m_b, m_s);
        e.r = in_row; e.c = in_col; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      if (cfg_load && mready) begin
        m_w = cfg_weights; m_b = cfg_bias; m_s = cfg_shift;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [71:0] win, input logic [3:0] r, input logic [3:0] c);
    bit acc;
    int n = 0;
    in_valid = 1'b1; in_window = win; in_row = r; in_col = c;
    do begin
      @(negedge clk); acc = in_ready;
      tick(); n++;
    end while (!acc && n < 200);
    check("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 300) begin tick(); n++; end
    check("drain", sb.size(), 0);
  endtask

  task automatic load_cfg(input logic [71:0] w, input logic [31:0] b, input logic [4:0] s);
    cfg_weights = w; cfg_bias = b; cfg_shift = s; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [71:0] wv, win;
    logic [31:0] b;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_weights = '0; cfg_bias = '0; cfg_shift = '0;
    in_valid = 1'b0; in_window = '0; in_row = '0; in_col = '0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'd0);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    send(rep(8'd50), 4'd2, 4'd2);
    drain();
    check("rst_weights_zero", $signed(last_d), 0);

    load_cfg(rep(8'd1), 32'd0, 5'd0);
    send(rep(8'd2), 4'd1, 4'd3);
    drain();
    check("basic_value", $signed(last_d), 18);
    check("basic_latency", last_lat, 3);

    load_cfg(rep(8'd127), 32'd0, 5'd0);
    send(rep(8'd127), 4'd0, 4'd1);
    drain();
    check("sat_pos", $signed(last_d), 127);
    send(rep(8'h80), 4'd0, 4'd2);
    drain();
`ifdef CONV3X3_MAC_RELU_EN
    check("sat_neg", $signed(last_d), 0);
`else
    check("sat_neg", $signed(last_d), -128);
`endif

    wv = '0; wv[4*8 +: 8] = 8'd1;
    load_cfg(wv, 32'd0, 5'd1);
    win = '0; win[4*8 +: 8] = 8'd5; win[8*8 +: 8] = 8'd100;
    send(win, 4'd5, 4'd5);
    drain();
    check("round_pos", $signed(last_d), 3);
    win[4*8 +: 8] = 8'hFB;
    send(win, 4'd5, 4'd6);
    drain();
`ifdef CONV3X3_MAC_RELU_EN
    check("round_neg", $signed(last_d), 0);
`else
    check("round_neg", $signed(last_d), -2);
`endif
    wv = '0; wv[7:0] = 8'd1;
    load_cfg(wv, 32'd0, 5'd0);
    win = '0; win[7:0] = 8'd7; win[8*8 +: 8] = 8'd100;
    send(win, 4'd2, 4'd0);
    drain();
    check("tap_order", $signed(last_d), 7);

    load_cfg(rep(8'd1), 32'd0, 5'd0);
    send(rep(8'd3), 4'd9, 4'd9);
    send(rep(8'd4), 4'd9, 4'd10);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("flush_no_out", out_valid, 1'b0);
      tick();
    end

    load_cfg(rep(8'd1), 32'd0, 5'd0);
    got.delete();
    send(rep(8'd0), 4'd3, 4'd0);
    send(rep(8'd1), 4'd3, 4'd1);
    send(rep(8'd2), 4'd3, 4'd2);
    out_ready = 1'b0;
    in_window = rep(8'd3); in_row = 4'd3; in_col = 4'd3;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_frozen", $signed(out_data), 0);
      tick();
    end
    out_ready = 1'b1;
    send(rep(8'd3), 4'd3, 4'd3);
    send(rep(8'd4), 4'd3, 4'd4);
    send(rep(8'd5), 4'd3, 4'd5);
    drain();
    check("bp_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("bp_order", $signed(got[i]), 9 * i);

    send(rep(8'd1), 4'd7, 4'd7);
    in_valid = 1'b0;
    cfg_weights = rep(8'd2); cfg_bias = '0; cfg_shift = '0; cfg_load = 1'b1;
    @(negedge clk);
    check("guard_cfg_busy", cfg_ready, 1'b0);
    tick();
    cfg_load = 1'b0;
    drain();
    check("guard_old_weights", $signed(last_d), 9);
    load_cfg(rep(8'd2), 32'd0, 5'd0);
    send(rep(8'd1), 4'd7, 4'd8);
    drain();
    check("guard_new_weights", $signed(last_d), 18);

    got.delete();
    cfg_weights = rep(8'd3); cfg_bias = 32'd100; cfg_shift = 5'd2; cfg_load = 1'b1;
    send(rep(8'd1), 4'd8, 4'd0);
    cfg_load = 1'b0;
    send(rep(8'd1), 4'd8, 4'd1);
    drain();
    check("same_edge_count", got.size(), 2);
    if (got.size() == 2) begin
      check("same_edge_old", $signed(got[0]), 18);
      check("same_edge_new", $signed(got[1]), 32);
    end

    rand_ready = 1;
    for (int round = 0; round < 6; round++) begin
      drain();
      b = (round % 3 == 0) ? $urandom : (32'($urandom_range(0, 4000)) - 32'd2000);
      load_cfg({$urandom, $urandom, $urandom}, b, 5'($urandom_range(0, 12)));
      for (int j = 0; j < 25; j++) begin
        if ($urandom_range(0, 5) == 0) begin
          cfg_weights = {$urandom, $urandom, $urandom};
          cfg_bias = $urandom; cfg_shift = 5'($urandom_range(0, 31));
          cfg_load = 1'b1;
        end
        send({$urandom, $urandom, $urandom}, 4'($urandom), 4'($urandom));
        cfg_load = 1'b0;
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
